leitor_fila: RTL and testbench
==============================

// Module: leitor_fila
// PURPOSE
//  Reader/drain end of the 8-entry byte queue. Watches the queue length, issues
//  one-cycle dequeue pulses, waits out the queue's read latency, captures the
//  byte and shifts it out bit-serially to a downstream sink with a valid/ready
//  handshake. Sits between the queue outputs and the serial output stage.
// PARAMETERS
//  WIDTH      8  word width; must match queue data width
//  DEQ_LAT    2  cycles from end of dequeue pulse to stable queue data (>=1)
//  MSB_FIRST  1  1: shift bit WIDTH-1 first; 0: bit 0 first
// PORTS
//  clk_10KHz     in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high reset
//  enable_in     in   1      1 = allowed to start draining a new word
//  len_in        in   8      queue occupancy (queue len_out)
//  data_in       in   WIDTH  queue head data (queue data_out)
//  sink_ready    in   1      downstream accepts current serial bit this cycle
//  dequeue_out   out  1      dequeue request to queue (dequeue_in), 1-cycle pulse
//  serial_out    out  1      current serial bit
//  serial_valid  out  1      serial_out holds a valid bit
//  word_done     out  1      1-cycle pulse after last bit of a word accepted
//  word_out      out  WIDTH  last word captured from the queue
//  busy          out  1      1 whenever state != IDLE
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset (sampled at a rising edge): state IDLE, bit counter 0, shift reg 0.
//    All outputs 0: dequeue_out, serial_out, serial_valid, word_done, word_out,
//    busy. Reset wins over every other condition, including mid-word. A word
//    in flight is dropped with no word_done.
//  - All outputs are registered or decoded from state only (Moore). No
//    combinational path from any input to any output.
//  - FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
//    IDLE : if enable_in && len_in != 0 -> REQ; else stay.
//    REQ  : dequeue_out=1 for exactly this cycle -> WAIT (counter loaded).
//    WAIT : DEQ_LAT cycles. At the edge leaving WAIT, capture data_in into the
//           shift reg and word_out -> SHIFT.
//    SHIFT: serial_valid=1. serial_out = current bit (MSB or LSB per MSB_FIRST).
//           A bit is consumed on an edge with sink_ready=1. sink_ready=0 holds
//           the bit indefinitely. After WIDTH bits consumed -> DONE.
//    DONE : word_done=1 for one cycle, serial_valid=0 -> IDLE.
//  - Queue timing: the queue registers the request on the edge after REQ and
//    updates data one edge later. DEQ_LAT=2 captures stable data. len_in lags
//    by one more edge, but it is fresh before the next IDLE evaluation.
//    Therefore exactly one dequeue pulse per word; never double-dequeue.
//  - Minimum per word: IDLE 1 + REQ 1 + WAIT DEQ_LAT + SHIFT WIDTH + DONE 1.
//    Default total: 13 cycles.
//  - Boundaries:
//    len_in=0: stay IDLE, no pulse.
//    enable_in dropping mid-word: current word completes, no new REQ.
//    sink_ready outside SHIFT: ignored.
//    len_in is treated as "nonzero", never as a count; no arithmetic on it.
//  - Bit counter width: clog2(WIDTH)+1. It must not wrap before WIDTH bits.
// TESTING
//  1 Reset with len_in=3, enable_in=1 -> all outputs 0 on the cycle after reset.
//    dequeue_out first rises 1 cycle after reset deasserts.
//  2 len_in=1, data_in=0xA5 after latency, sink_ready=1 constantly.
//    -> dequeue_out high exactly 1 cycle.
//    -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles.
//    -> word_done pulse; word_out=0xA5; 13 cycles total.
//  3 Same as 2 with sink_ready alternating 1/0 -> each bit held while ready=0.
//    SHIFT lasts 15-16 cycles; bit order unchanged.
//  4 Real queue preloaded with 0x01,0x80,0xFF -> three words serialized in
//    order, exactly 3 dequeue pulses, then IDLE with len_in=0.
//  5 enable_in=0 with len_in=4 -> no pulse for 50 cycles.
//    Drop enable_in during SHIFT -> word finishes, no further REQ.
//  6 Reset asserted at bit 4 of 0x3C -> next cycle serial_valid=0, busy=0.
//    No word_done; word_out=0.

Source files
------------

// File: rtl/leitor_fila.sv
// -----------------------------------------------------------------------------
// leitor_fila
//   Drain side of the 8-entry byte queue. While enabled and the queue reports
//   a nonzero length, it issues a single dequeue pulse. It then waits out the
//   queue read latency and captures the head word. Finally it shifts the word
//   out one bit at a time to a downstream sink using a valid/ready handshake.
//
//   Per-word sequence: IDLE -> REQ -> WAIT (DEQ_LAT cycles) -> SHIFT -> DONE.
//   Every output is a flop, so no path exists from any input to any output.
//
// Parameters
//   WIDTH      word width, equal to the queue data width
//   DEQ_LAT    cycles from the end of the dequeue pulse to stable queue data
//              (must be >= 1)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk_10KHz     in   system clock; all logic runs on its rising edge
//   reset         in   synchronous, active-high reset
//   enable_in     in   permits the drain of a new word to start
//   len_in        in   queue occupancy; only its zero/nonzero status is used
//   data_in       in   queue head data
//   sink_ready    in   sink accepts the current serial bit this cycle
//   dequeue_out   out  one-cycle dequeue request to the queue
//   serial_out    out  current serial bit (0 outside SHIFT)
//   serial_valid  out  serial_out carries a valid bit
//   word_done     out  one-cycle pulse after the last bit is accepted
//   word_out      out  last word captured from the queue
//   busy          out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module leitor_fila #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEQ_LAT   = 2,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk_10KHz,
   input  logic             reset,
   input  logic             enable_in,
   input  logic [7:0]       len_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sink_ready,
   output logic             dequeue_out,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic [WIDTH-1:0] word_out,
   output logic             busy
);

   // The extra counter bit allows the count to reach WIDTH without wrapping.
   localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
   localparam int unsigned WAIT_W = $clog2(DEQ_LAT) + 1;

   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(DEQ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  shift_d;
   logic [WIDTH-1:0]  word_q;
   logic              dequeue_q;
   logic              serial_q;
   logic              valid_q;
   logic              done_q;
   logic              busy_q;

   // Returns the bit that leaves first, based on the shift direction.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Shift register contents once the current bit has been consumed.
   always_comb begin
      // NOTE: every path assigns shift_d, so no latch can be inferred here.
      if (MSB_FIRST) begin
         shift_d = shift_q << 1;
      end else begin
         shift_d = shift_q >> 1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk_10KHz) begin
      if (reset) begin
         // Reset has priority over all other conditions. Any word in flight
         // is dropped without a word_done pulse.
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         shift_q    <= '0;
         word_q     <= '0;
         dequeue_q  <= 1'b0;
         serial_q   <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         // Pulse outputs default low; the states that need them raise them.
         dequeue_q <= 1'b0;
         done_q    <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               // len_in is only tested as empty or non-empty.
               if (enable_in && (len_in != 8'd0)) begin
                  state_q   <= S_REQ;
                  dequeue_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end

            S_REQ: begin
               state_q    <= S_WAIT;
               wait_cnt_q <= WAIT_LOAD;
            end

            S_WAIT: begin
               if (wait_cnt_q == '0) begin
                  // Queue data is stable at this edge, so capture it now.
                  state_q   <= S_SHIFT;
                  shift_q   <= data_in;
                  word_q    <= data_in;
                  serial_q  <= first_bit(data_in);
                  valid_q   <= 1'b1;
                  bit_cnt_q <= '0;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 1'b1;
               end
            end

            S_SHIFT: begin
               // When sink_ready is low, the current bit is held.
               if (sink_ready) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q   <= S_DONE;
                     valid_q   <= 1'b0;
                     serial_q  <= 1'b0;
                     done_q    <= 1'b1;
                     bit_cnt_q <= '0;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     shift_q   <= shift_d;
                     serial_q  <= first_bit(shift_d);
                  end
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q  <= S_IDLE;
               valid_q  <= 1'b0;
               serial_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign dequeue_out  = dequeue_q;
   assign serial_out   = serial_q;
   assign serial_valid = valid_q;
   assign word_done    = done_q;
   assign word_out     = word_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_leitor_fila.sv
// -----------------------------------------------------------------------------
// tb_leitor_fila
//   Testbench for leitor_fila. It contains a model of the byte queue that
//   follows the queue's request, data and length timing. A word-level
//   scoreboard expects each pushed word to come out in push order, MSB first,
//   with one bit per accepted handshake, one dequeue per word and a
//   word_done pulse that carries the word. Fixed vectors and hand-written
//   sequences cover the timing corners. A random phase then stresses the
//   handshake.
// -----------------------------------------------------------------------------
module tb_leitor_fila;

   logic       clk_10KHz = 1'b0;
   logic       reset;
   logic       enable_in;
   logic [7:0] len_in;
   logic [7:0] data_in;
   logic       sink_ready;
   logic       dequeue_out;
   logic       serial_out;
   logic       serial_valid;
   logic       word_done;
   logic [7:0] word_out;
   logic       busy;

   always #5 clk_10KHz = ~clk_10KHz;

   leitor_fila #(
      .WIDTH    (8),
      .DEQ_LAT  (2),
      .MSB_FIRST(1'b1)
   ) dut (
      .clk_10KHz   (clk_10KHz),
      .reset       (reset),
      .enable_in   (enable_in),
      .len_in      (len_in),
      .data_in     (data_in),
      .sink_ready  (sink_ready),
      .dequeue_out (dequeue_out),
      .serial_out  (serial_out),
      .serial_valid(serial_valid),
      .word_done   (word_done),
      .word_out    (word_out),
      .busy        (busy)
   );

   typedef struct {
      logic [7:0] data;
      bit         alt_ready;
      logic [7:0] exp_word;
      int         exp_deq;
      int         shift_min;
      int         shift_max;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   // Queue model: contents plus the delay line from request to data/length.
   logic [7:0] tbq[$];
   logic       qd1 = 1'b0, qd2 = 1'b0, qd3 = 1'b0;

   // Scoreboard state.
   logic [7:0] exp_words[$];
   int         n_push = 0, n_deq = 0, n_fin = 0, n_valid = 0, bit_idx = 0, cyc = 0;
   int         deq_cyc[$];
   int         ready_mode = 0;  // 0: always 1, 1: toggle, 2: random, 3: hold 0

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic push_word(input logic [7:0] w);
      tbq.push_back(w);
      exp_words.push_back(w);
      n_push++;
      len_in = 8'(tbq.size() + (qd3 ? 1 : 0));
   endtask

   // The in-flight word (dequeued but not yet finished) is lost on reset.
   task automatic flush_in_flight();
      logic [7:0] w;
      if (n_deq > n_fin && exp_words.size() > 0) begin
         w = exp_words.pop_front();
         n_fin++;
      end
      bit_idx = 0;
   endtask

   // Advances one clock. The queue model and the scoreboard update at the
   // falling edge, away from the DUT's active edge.
   task automatic tick();
      logic [7:0] w;
      @(negedge clk_10KHz);
      cyc++;
      // The queue latches the request one edge after REQ, updates its data
      // one edge later, and updates its length one edge after that.
      if (qd2 && tbq.size() > 0) data_in = tbq.pop_front();
      qd3 = qd2;
      qd2 = qd1;
      qd1 = dequeue_out;
      len_in = 8'(tbq.size() + (qd3 ? 1 : 0));

      if (dequeue_out) begin
         n_deq++;
         deq_cyc.push_back(cyc);
      end
      if (serial_valid) n_valid++;
      if (word_done) begin
         if (exp_words.size() == 0) fail("word_done_unexpected");
         else begin
            check("deq_per_word", n_deq, n_fin + 1);
            check("word_out", word_out, exp_words[0]);
            check("bits_per_word", bit_idx, 8);
            w = exp_words.pop_front();
            n_fin++;
            bit_idx = 0;
         end
      end

      case (ready_mode)
         0:       sink_ready = 1'b1;
         1:       sink_ready = ~sink_ready;
         2:       sink_ready = 1'($urandom_range(0, 1));
         default: sink_ready = 1'b0;
      endcase

      // A bit that is valid now and sees ready at the next edge is consumed.
      if (serial_valid && sink_ready) begin
         if (exp_words.size() == 0 || bit_idx > 7) fail("serial_bit_unexpected");
         else begin
            w = exp_words[0];
            check("serial_bit", serial_out, w[7-bit_idx]);
            bit_idx++;
         end
      end
   endtask

   task automatic drain(input int max_cyc, input string name);
      int i = 0;
      while (i < max_cyc && !(n_fin == n_push && !busy)) begin
         tick();
         i++;
      end
      check(name, n_fin, n_push);
      check({name, "_idle"}, busy, 0);
   endtask

   initial begin
      vec_t vecs[6];
      int   d0, v0, f0, k, shift_cycles;

      reset      = 1'b1;
      enable_in  = 1'b0;
      sink_ready = 1'b0;
      len_in     = 8'd0;
      data_in    = 8'd0;

      // Reset with three words waiting and enable high.
      enable_in = 1'b1;
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      repeat (3) tick();
      check("rst_ctrl_outputs", {dequeue_out, serial_out, serial_valid, word_done, busy}, 0);
      check("rst_word_out", word_out, 0);
      reset = 1'b0;
      tick();
      check("first_deq_after_reset", dequeue_out, 1);
      drain(200, "rst_drain");

      // Single-word vectors, with sink_ready held high or toggling.
      vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1, 8, 8};
      vecs[1] = '{8'hA5, 1'b1, 8'hA5, 1, 15, 16};
      vecs[2] = '{8'h01, 1'b0, 8'h01, 1, 8, 8};
      vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 15, 16};
      vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1, 8, 8};
      vecs[5] = '{8'h3C, 1'b1, 8'h3C, 1, 15, 16};
      foreach (vecs[i]) begin
         d0 = n_deq;
         v0 = n_valid;
         f0 = n_fin;
         k  = 0;
         ready_mode = vecs[i].alt_ready ? 1 : 0;
         enable_in  = 1'b1;
         push_word(vecs[i].data);
         while (n_fin == f0 && k < 100) begin
            tick();
            k++;
         end
         shift_cycles = n_valid - v0;
         check("vec_done", n_fin, f0 + 1);
         check("vec_deq_count", n_deq - d0, vecs[i].exp_deq);
         check("vec_shift_min", shift_cycles >= vecs[i].shift_min, 1);
         check("vec_shift_max", shift_cycles <= vecs[i].shift_max, 1);
         check("vec_word_out", word_out, vecs[i].exp_word);
         tick();
         check("vec_idle", busy, 0);
      end

      // Three queued words drained back to back: 13-cycle spacing.
      ready_mode = 0;
      deq_cyc.delete();
      push_word(8'h01);
      push_word(8'h80);
      push_word(8'hFF);
      drain(120, "q3_drain");
      repeat (10) tick();
      check("q3_deq_pulses", deq_cyc.size(), 3);
      if (deq_cyc.size() == 3) begin
         check("q3_period_1", deq_cyc[1] - deq_cyc[0], 13);
         check("q3_period_2", deq_cyc[2] - deq_cyc[1], 13);
      end
      check("q3_word_out", word_out, 8'hFF);

      // enable_in low: no dequeue even though the queue holds four words.
      enable_in = 1'b0;
      d0 = n_deq;
      push_word(8'h5A);
      push_word(8'hC3);
      push_word(8'h0F);
      push_word(8'hF0);
      repeat (50) tick();
      check("dis_no_deq", n_deq - d0, 0);
      check("dis_idle", busy, 0);
      // Drop enable_in during SHIFT: this word completes, no further request.
      enable_in = 1'b1;
      k = 0;
      while (!serial_valid && k < 20) begin
         tick();
         k++;
      end
      check("dis_reached_shift", serial_valid, 1);
      enable_in = 1'b0;
      f0 = n_fin;
      k = 0;
      while (n_fin == f0 && k < 40) begin
         tick();
         k++;
      end
      check("dis_word_finished", n_fin, f0 + 1);
      repeat (30) tick();
      check("dis_single_deq", n_deq - d0, 1);
      check("dis_idle_after", busy, 0);
      enable_in = 1'b1;
      drain(200, "dis_drain");

      // Reset while bit 4 of 0x3C is on the output.
      ready_mode = 0;
      push_word(8'h3C);
      k = 0;
      while (bit_idx < 4 && k < 40) begin
         tick();
         k++;
      end
      ready_mode = 3;
      tick();
      check("mid_valid", serial_valid, 1);
      check("mid_bit4", serial_out, 1);
      reset = 1'b1;
      flush_in_flight();
      f0 = n_fin;
      tick();
      check("mid_rst_valid", serial_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_word_out", word_out, 0);
      check("mid_rst_deq", dequeue_out, 0);
      reset = 1'b0;
      ready_mode = 0;
      repeat (30) tick();
      check("mid_no_word_done", n_fin, f0);
      check("mid_idle", busy, 0);

      // Random phase: random pushes, enable and sink_ready.
      ready_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0 && (tbq.size() + (qd3 ? 1 : 0)) < 8)
            push_word(8'($urandom));
         enable_in = ($urandom_range(0, 99) < 85);
         tick();
      end
      enable_in  = 1'b1;
      ready_mode = 0;
      drain(2000, "rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
